// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and the add/sub mode encoding.
package pipe_adder_pkg;
  localparam int   DEFAULT_WIDTH  = 12;
  localparam int   DEFAULT_STAGES = 3;
  localparam logic MODE_ADD       = 1'b0;
  localparam logic MODE_SUB       = 1'b1;
endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; master drives operands, slave is the adder.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder_add_slice.sv
// One SW-bit ripple slice of the pipelined adder; the only combinational carry path per stage.
module add_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] x,
  input  logic [SW-1:0] y,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, one SW-bit slice per stage with registered carries between stages.
// Optional build macro PIPE_ADDER_SAT_EN saturates overflowing results to signed max/min.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic        clk,
  input  logic        reset,
  pipe_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Per-stage inputs (from ports or previous register) and next-state values
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             c_in [STAGES];
  logic             c_nx [STAGES];
  logic             v_in [STAGES];

  logic [WIDTH-1:0] a_r  [STAGES];
  logic [WIDTH-1:0] b_r  [STAGES];
  logic [WIDTH-1:0] s_r  [STAGES];
  logic             c_r  [STAGES];
  logic             v_r  [STAGES];

  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-1:0] sum_r;
  logic             msb_carry;
  logic             ovf_nx;
  logic             ovf_r;

  assign en           = bus.out_ready | ~v_r[STAGES-1];
  assign bus.in_ready = en | reset;

  // Operand conditioning: subtraction is A + ~B + 1 and ignores cin
  always_comb begin
    if (bus.sub == MODE_SUB) begin
      b_eff   = ~bus.b;
      cin_eff = 1'b1;
    end else begin
      b_eff   = bus.b;
      cin_eff = bus.cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] slice_s;

    if (k == 0) begin : g_head
      assign a_in[k] = bus.a;
      assign b_in[k] = b_eff;
      assign s_in[k] = '0;
      assign c_in[k] = cin_eff;
      assign v_in[k] = bus.in_valid;
    end else begin : g_link
      assign a_in[k] = a_r[k-1];
      assign b_in[k] = b_r[k-1];
      assign s_in[k] = s_r[k-1];
      assign c_in[k] = c_r[k-1];
      assign v_in[k] = v_r[k-1];
    end

    add_slice #(.SW(SW)) u_slice (
      .x  (a_in[k][k*SW +: SW]),
      .y  (b_in[k][k*SW +: SW]),
      .ci (c_in[k]),
      .s  (slice_s),
      .co (c_nx[k])
    );

    // Slices not yet computed are still zero, so OR merges this stage's bits in
    assign s_nx[k] = s_in[k] | (WIDTH'(slice_s) << (k*SW));
  end

  // Carry into the MSB recovered from the MSB sum bit and its operand bits
  assign msb_carry = s_nx[STAGES-1][WIDTH-1] ^ a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1];
  assign ovf_nx    = msb_carry ^ c_nx[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
  // Clamp to signed max/min on overflow, direction chosen by A's sign
  always_comb begin
    if (!ovf_nx) begin
      sum_nx = s_nx[STAGES-1];
    end else if (a_in[STAGES-1][WIDTH-1]) begin
      sum_nx = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sum_nx = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_nx = s_nx[STAGES-1];
`endif

  // Stage registers: reset clears everything, otherwise all stages advance together on en
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
        s_r[i] <= '0;
        c_r[i] <= 1'b0;
        v_r[i] <= 1'b0;
      end
      sum_r <= '0;
      ovf_r <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < STAGES; i++) begin
        a_r[i] <= a_in[i];
        b_r[i] <= b_in[i];
        s_r[i] <= s_nx[i];
        c_r[i] <= c_nx[i];
        v_r[i] <= v_in[i];
      end
      sum_r <= sum_nx;
      ovf_r <= ovf_nx;
    end
  end

  assign bus.out_valid = v_r[STAGES-1];
  assign bus.sum       = sum_r;
  assign bus.cout      = c_r[STAGES-1];
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=12, STAGES=3); expectations follow PIPE_ADDER_SAT_EN.
module tb_pipe_adder;
  localparam int WIDTH  = 12;
  localparam int STAGES = 3;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [11:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;
  bit   chk_lat = 1'b0;
  exp_t q[$];

  pipe_adder_if #(.WIDTH(WIDTH)) bus();

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [11:0] ma, input logic [11:0] mb,
                                 input logic mc, input logic ms);
    logic [11:0] bb;
    logic        ci;
    logic [12:0] full;
    exp_t        e;
    bb   = ms ? ~mb : mb;
    ci   = ms ? 1'b1 : mc;
    full = {1'b0, ma} + {1'b0, bb} + {12'd0, ci};
    e.sum  = full[11:0];
    e.cout = full[12];
    e.ovf  = (ma[11] == bb[11]) && (full[11] != ma[11]);
    if (SAT && e.ovf) e.sum = ma[11] ? 12'h800 : 12'h7FF;
    e.cyc = 0;
    return e;
  endfunction

  // Called at posedge+#1; offers one operand set until the DUT takes it
  task automatic send(input logic [11:0] ta, input logic [11:0] tbv,
                      input logic tc, input logic ts, input exp_t e);
    bit   accepted;
    exp_t ent;
    accepted = 1'b0;
    bus.a = ta; bus.b = tbv; bus.cin = tc; bus.sub = ts; bus.in_valid = 1'b1;
    for (int t = 0; t < 64 && !accepted; t++) begin
      @(negedge clk);
      if (bus.in_ready && !reset) begin
        ent = e;
        ent.cyc = cyc;
        q.push_back(ent);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_accept", 32'(accepted), 32'd1);
  endtask

  task automatic send_rand();
    logic [11:0] ra, rb;
    logic        rc, rs;
    ra = 12'($urandom); rb = 12'($urandom);
    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Consumer ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Output monitor: handshake rule, stall stability, in-order scoreboard
  initial begin
    logic        prev_stall;
    logic [11:0] prev_sum;
    logic        prev_cout, prev_ovf;
    exp_t        e;
    prev_stall = 1'b0; prev_sum = 12'h000; prev_cout = 1'b0; prev_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("in_ready_rst", 32'(bus.in_ready), 32'd1);
        q.delete();
        prev_stall = 1'b0;
      end else begin
        check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_sum", 32'(bus.sum), 32'(prev_sum));
          check("hold_cout", 32'(bus.cout), 32'(prev_cout));
          check("hold_ovf", 32'(bus.ovf), 32'(prev_ovf));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_out", 32'(bus.out_valid), 32'd0);
          end else begin
            e = q.pop_front();
            check("sum", 32'(bus.sum), 32'(e.sum));
            check("cout", 32'(bus.cout), 32'(e.cout));
            check("ovf", 32'(bus.ovf), 32'(e.ovf));
            if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'(STAGES));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_sum   = bus.sum;
        prev_cout  = bus.cout;
        prev_ovf   = bus.ovf;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a = 12'h000; bus.b = 12'h000;
    bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    #1;

    // Directed corner cases with exact latency
    chk_lat = 1'b1;
    send(12'h0FF, 12'h001, 1'b0, 1'b0, mk(12'h100, 1'b0, 1'b0));
    send(12'h7FF, 12'h001, 1'b0, 1'b0, mk(SAT ? 12'h7FF : 12'h800, 1'b0, 1'b1));
    send(12'h000, 12'h001, 1'b0, 1'b1, mk(12'hFFF, 1'b0, 1'b0));
    send(12'h800, 12'h001, 1'b0, 1'b1, mk(SAT ? 12'h800 : 12'h7FF, 1'b1, 1'b1));
    send(12'hFFF, 12'h000, 1'b1, 1'b0, mk(12'h000, 1'b1, 1'b0));
    send(12'h800, 12'h800, 1'b0, 1'b0, mk(SAT ? 12'h800 : 12'h000, 1'b1, 1'b1));
    send(12'h005, 12'h003, 1'b1, 1'b1, mk(12'h002, 1'b1, 1'b0));
    send(12'h0F0, 12'h00F, 1'b1, 1'b0, mk(12'h100, 1'b0, 1'b0));
    wait_drain();
    chk_lat = 1'b0;

    // Back-to-back stream under the 1,0,0,1 ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_rand();
    wait_drain();
    rdy_mode = 0;

    // Reset with two operations in flight: neither may emerge
    @(posedge clk);
    #1;
    send(12'h123, 12'h456, 1'b0, 1'b0, mk(12'h579, 1'b0, 1'b0));
    send(12'h321, 12'h111, 1'b0, 1'b1, mk(12'h210, 1'b1, 1'b0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_sum", 32'(bus.sum), 32'd0);
    repeat (8) @(posedge clk);
    #1;

    // Random traffic with bubbles and random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    wait_drain();
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
